// File: rtl/sync_fifo_flex_pkg.sv
// Shared types and helpers for the sync_fifo_flex block.
package fifo_pkg;

    // Accepted-operation decode that drives the occupancy update.
    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_WR   = 2'd1,
        OP_RD   = 2'd2,
        OP_WRRD = 2'd3
    } fifo_op_e;

    // ceil(log2(n)), never below 1 so a 1-bit address always exists.
    function automatic int clog2_safe(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sync_fifo_flex_if.sv
// Producer/consumer bus of sync_fifo_flex. The master side drives requests,
// the slave side (the FIFO) returns data, flags and occupancy.
interface sync_fifo_flex_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int AW = clog2_safe(DEPTH);

    logic             flush;
    logic             wr_en;
    logic [WIDTH-1:0] data_in;
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, wr_en, data_in, rd_en,
        input  data_out, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

    modport slave (
        input  flush, wr_en, data_in, rd_en,
        output data_out, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_flex_ram.sv
// Storage array for sync_fifo_flex: one synchronous write port, one
// asynchronous read port. Contents are deliberately not reset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = clog2_safe(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the addressed entry on an accepted write.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, flush and sticky overflow/underflow flags.
// Build option: SYNC_FIFO_FWFT_EN selects first-word fall-through output;
// when undefined, data_out is registered and updates on an accepted read.
module sync_fifo_flex
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    sync_fifo_flex_if.slave   bus
);

    localparam int          AW       = clog2_safe(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_AF   = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] CNT_AE   = (AW+1)'(AE_THRESH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("sync_fifo_flex: DEPTH must be a power of two >= 2");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_chk_af
        $error("sync_fifo_flex: AF_THRESH must be in 1..DEPTH");
    end
    if ((AE_THRESH < 0) || (AE_THRESH >= DEPTH)) begin : g_chk_ae
        $error("sync_fifo_flex: AE_THRESH must be in 0..DEPTH-1");
    end

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             full_w, empty_w;
    logic             wr_acc, rd_acc;
    fifo_op_e         op;
    logic [WIDTH-1:0] ram_rdata;

    assign full_w  = (count_q == CNT_FULL);
    assign empty_w = (count_q == '0);

    // Accept decode and next-state for pointers, occupancy and sticky errors.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        wr_acc   = 1'b0;
        rd_acc   = 1'b0;
        op       = OP_IDLE;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_acc = bus.wr_en && !full_w;
            rd_acc = bus.rd_en && !empty_w;
            ovf_d  = ovf_q | (bus.wr_en & full_w);
            unf_d  = unf_q | (bus.rd_en & empty_w);

            unique case ({rd_acc, wr_acc})
                2'b01:   op = OP_WR;
                2'b10:   op = OP_RD;
                2'b11:   op = OP_WRRD;
                default: op = OP_IDLE;
            endcase

            if (wr_acc) wr_ptr_d = wr_ptr_q + CNT_ONE;
            if (rd_acc) rd_ptr_d = rd_ptr_q + CNT_ONE;

            case (op)
                OP_WR:   count_d = count_q + CNT_ONE;
                OP_RD:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer, occupancy and sticky-flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (bus.data_in),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // Head of queue shown directly; meaningless while empty.
    assign bus.data_out = ram_rdata;
`else
    logic [WIDTH-1:0] dout_q;

    // Registered read data, held between accepted reads and across flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else if (rd_acc) begin
            dout_q <= ram_rdata;
        end
    end

    assign bus.data_out = dout_q;
`endif

    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_q >= CNT_AF);
    assign bus.almost_empty = (count_q <= CNT_AE);
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Self-checking bench for sync_fifo_flex (WIDTH=8, DEPTH=8, AF=6, AE=1).
module tb_sync_fifo_flex;

    localparam int W     = 8;
    localparam int D     = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sync_fifo_flex_if #(.WIDTH(W), .DEPTH(D)) bus ();

    sync_fifo_flex #(
        .WIDTH     (W),
        .DEPTH     (D),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: a queue of words plus the sticky flags.
    logic [W-1:0] mq[$];
    logic         m_ovf, m_unf;
    logic [W-1:0] m_dout;

    typedef struct {
        logic         f, w, r;
        logic [W-1:0] d;
        int           cnt;
        logic [W-1:0] dout;
        logic         ovf, unf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic f, input logic w, input logic r, input logic [W-1:0] d);
        bus.flush   = f;
        bus.wr_en   = w;
        bus.rd_en   = r;
        bus.data_in = d;
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_dout = '0;
    endtask

    task automatic model_step(input logic f, input logic w, input logic r, input logic [W-1:0] d);
        bit was_full, was_empty;
        was_full  = (mq.size() == D);
        was_empty = (mq.size() == 0);
        if (f) begin
            mq.delete();
        end else begin
            if (w && was_full)  m_ovf = 1'b1;
            if (r && was_empty) m_unf = 1'b1;
            if (r && !was_empty) m_dout = mq.pop_front();
            if (w && !was_full)  mq.push_back(d);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = mq.size();
        check({tag, ".count"}, 32'(bus.count), 32'(n));
        check({tag, ".empty"}, 32'(bus.empty), 32'(n == 0));
        check({tag, ".full"},  32'(bus.full),  32'(n == D));
        check({tag, ".afull"}, 32'(bus.almost_full),  32'(n >= AF));
        check({tag, ".aempty"}, 32'(bus.almost_empty), 32'(n <= AE));
        check({tag, ".ovf"},   32'(bus.overflow),  32'(m_ovf));
        check({tag, ".unf"},   32'(bus.underflow), 32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
        if (n > 0) check({tag, ".dout"}, 32'(bus.data_out), 32'(mq[0]));
`else
        check({tag, ".dout"}, 32'(bus.data_out), 32'(m_dout));
`endif
    endtask

    task automatic cyc(input string tag, input logic f, input logic w, input logic r, input logic [W-1:0] d);
        drive(f, w, r, d);
        tick();
        model_step(f, w, r, d);
        check_all(tag);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0);
        repeat (cycles) tick();
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] held;
        logic [W-1:0] seq;

        // Directed vectors from a freshly reset FIFO.
        vecs[0] = '{1'b0, 1'b1, 1'b0, 8'h11, 1, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h22, 2, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 8'h11, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 8'h33, 1, 8'h22, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h33, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h33, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 8'h44, 1, 8'h33, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 8'h55, 0, 8'h33, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 8'h66, 1, 8'h33, 1'b0, 1'b1};

        // Reset state.
        do_reset(2);
        #1;
        check("rst.count", 32'(bus.count), 32'd0);
        check("rst.empty", 32'(bus.empty), 32'd1);
        check("rst.aempty", 32'(bus.almost_empty), 32'd1);
        check("rst.full", 32'(bus.full), 32'd0);
        check("rst.afull", 32'(bus.almost_full), 32'd0);
        check("rst.ovf", 32'(bus.overflow), 32'd0);
        check("rst.unf", 32'(bus.underflow), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
        check("rst.dout", 32'(bus.data_out), 32'h00);
`endif

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].f, vecs[i].w, vecs[i].r, vecs[i].d);
            tick();
            model_step(vecs[i].f, vecs[i].w, vecs[i].r, vecs[i].d);
            check($sformatf("vec%0d.count", i), 32'(bus.count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d.empty", i), 32'(bus.empty), 32'(vecs[i].cnt == 0));
            check($sformatf("vec%0d.aempty", i), 32'(bus.almost_empty), 32'(vecs[i].cnt <= AE));
            check($sformatf("vec%0d.ovf", i), 32'(bus.overflow), 32'(vecs[i].ovf));
            check($sformatf("vec%0d.unf", i), 32'(bus.underflow), 32'(vecs[i].unf));
`ifndef SYNC_FIFO_FWFT_EN
            check($sformatf("vec%0d.dout", i), 32'(bus.data_out), 32'(vecs[i].dout));
`endif
        end

        // Fill then drain, with overflow and underflow.
        do_reset(2);
        for (int i = 1; i <= 8; i++) begin
            cyc($sformatf("fill%0d", i), 1'b0, 1'b1, 1'b0, 8'(i));
            check($sformatf("fill%0d.afull", i), 32'(bus.almost_full), 32'(i >= 6));
        end
        check("fill.full", 32'(bus.full), 32'd1);
        cyc("ovf", 1'b0, 1'b1, 1'b0, 8'hAA);
        check("ovf.flag", 32'(bus.overflow), 32'd1);
        check("ovf.count", 32'(bus.count), 32'd8);
        for (int i = 1; i <= 8; i++) begin
            cyc($sformatf("drain%0d", i), 1'b0, 1'b0, 1'b1, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
            check($sformatf("drain%0d.word", i), 32'(bus.data_out), 32'(i));
`endif
        end
        check("drain.empty", 32'(bus.empty), 32'd1);
        cyc("unf", 1'b0, 1'b0, 1'b1, 8'h00);
        check("unf.flag", 32'(bus.underflow), 32'd1);
        check("ovf.sticky", 32'(bus.overflow), 32'd1);

        // Simultaneous read/write at count 4, pointers wrap.
        do_reset(1);
        seq = 8'h20;
        for (int i = 0; i < 4; i++) begin
            cyc("sim.pre", 1'b0, 1'b1, 1'b0, seq);
            seq++;
        end
        for (int i = 0; i < 20; i++) begin
            cyc($sformatf("sim%0d", i), 1'b0, 1'b1, 1'b1, seq);
            seq++;
        end
        for (int i = 0; i < 4; i++) begin
            cyc("sim.top", 1'b0, 1'b1, 1'b0, seq);
            seq++;
        end
        cyc("sim.full_both", 1'b0, 1'b1, 1'b1, seq);
        check("sim.full_both.count", 32'(bus.count), 32'd7);
        check("sim.full_both.ovf", 32'(bus.overflow), 32'd1);

        // Flush at count 5 with both enables high.
        cyc("fl.pre1", 1'b0, 1'b0, 1'b1, 8'h00);
        cyc("fl.pre2", 1'b0, 1'b0, 1'b1, 8'h00);
        check("fl.pre.count", 32'(bus.count), 32'd5);
        held = bus.data_out;
        cyc("fl", 1'b1, 1'b1, 1'b1, 8'h99);
        check("fl.count", 32'(bus.count), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
        check("fl.dout_held", 32'(bus.data_out), 32'(held));
`endif
        cyc("fl.wr", 1'b0, 1'b1, 1'b0, 8'h5C);
`ifdef SYNC_FIFO_FWFT_EN
        check("fl.fwft5c", 32'(bus.data_out), 32'h5C);
`endif
        cyc("fl.rd", 1'b0, 1'b0, 1'b1, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
        check("fl.rd5c", 32'(bus.data_out), 32'h5C);
`endif

        // Reset in the middle of operation at count 3.
        for (int i = 0; i < 3; i++) cyc("mr.pre", 1'b0, 1'b1, 1'b0, 8'hE0 + 8'(i));
        do_reset(1);
        #1;
        check_all("mr");
        cyc("mr.rd", 1'b0, 1'b0, 1'b1, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
        check("mr.no_old", 32'(bus.data_out), 32'h00);
`endif

        // Randomized traffic against the queue model.
        do_reset(1);
        for (int i = 0; i < 600; i++) begin
            logic f, w, r;
            f = ($urandom_range(0, 39) == 0);
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 50);
            if ($urandom_range(0, 149) == 0) begin
                do_reset(1);
                #1;
                check_all("rnd.rst");
            end else begin
                cyc("rnd", f, w, r, 8'($urandom));
            end
        end

        drive(1'b0, 1'b0, 1'b0, '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
